// File: rtl/fsm_moore_2always.sv
// ---------------------------------------------------------------------------
// fsm_moore_2always
// Two-bit Moore up/down/clear counter built as a four-state FSM.
//
// Ports
//   Clk     in   1  system clock, rising-edge active
//   Rst     in   1  asynchronous reset, active low (forces S0)
//   X       in   2  mode: 0 hold, 1 count up, 2 count down, 3 clear
//   En      in   1  enable, active high; En=0 holds for any X
//   Cuenta  out  2  current count, decoded from state only
//
// state | meaning
// ------+-------------------------------
// S0    | count 0 (reset / clear state)
// S1    | count 1
// S2    | count 2
// S3    | count 3
// ---------------------------------------------------------------------------
module fsm_moore_2always (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] X,
  input  logic       En,
  output logic [1:0] Cuenta
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_UP    = 2'd1,
    MODE_DOWN  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;

  state_t     state_q, state_d;
  logic [1:0] cuenta_q, cuenta_d;
  mode_t      mode;

  assign mode = mode_t'(X);

  // Next-state logic. The default arm sends any unexpected state back to S0.
  always_comb begin
    state_d = state_q;
    if (En) begin
      unique case (mode)
        MODE_HOLD:  state_d = state_q;
        MODE_UP: begin
          case (state_q)
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = S0;
            default: state_d = S0;
          endcase
        end
        MODE_DOWN: begin
          case (state_q)
            S0:      state_d = S3;
            S1:      state_d = S0;
            S2:      state_d = S1;
            S3:      state_d = S2;
            default: state_d = S0;
          endcase
        end
        MODE_CLEAR: state_d = S0;
        default:    state_d = S0;
      endcase
    end
  end

  // Output decode of the next state, so the registered output always equals
  // the decode of the registered state (pure Moore, no path from X/En).
  always_comb begin
    cuenta_d = 2'd0;
    case (state_d)
      S0:      cuenta_d = 2'd0;
      S1:      cuenta_d = 2'd1;
      S2:      cuenta_d = 2'd2;
      S3:      cuenta_d = 2'd3;
      default: cuenta_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S0;
      cuenta_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cuenta_q <= cuenta_d;
    end
  end

  assign Cuenta = cuenta_q;

endmodule

// File: tb/tb_fsm_moore_2always.sv
// ---------------------------------------------------------------------------
// tb_fsm_moore_2always
// Directed bench for the two-bit Moore counter. Each step drives X/En,
// queues the expected count, and after the next rising edge pops and checks.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_fsm_moore_2always;

  logic       Clk;
  logic       Rst;
  logic [1:0] X;
  logic       En;
  logic [1:0] Cuenta;

  int n_checks;
  int n_fail;
  logic [1:0] exp_q[$];

  fsm_moore_2always dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .X      (X),
    .En     (En),
    .Cuenta (Cuenta)
  );

  initial Clk = 1'b0;
  always #1 Clk = ~Clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: Cuenta=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive inputs, queue expectation, wait one rising edge, compare.
  task automatic step(input string tag, input logic [1:0] x_v, input logic en_v,
                      input logic [1:0] expv);
    logic [1:0] e;
    X  = x_v;
    En = en_v;
    exp_q.push_back(expv);
    @(posedge Clk);
    #0.5;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, Cuenta, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    X   = 2'd0;
    En  = 1'b0;
    Rst = 1'b1;

    // Reset asserted asynchronously, before any rising edge
    #0.2 Rst = 1'b0;
    #0.2 check("reset_immediate", Cuenta, 2'd0);
    #2.0 check("reset_held", Cuenta, 2'd0);
    Rst = 1'b1;
    step("after_release", 2'd0, 1'b0, 2'd0);

    // Hold with En=1, X=0
    for (int i = 0; i < 5; i++) step("hold_x0", 2'd0, 1'b1, 2'd0);
    // En=0 overrides every mode
    step("en0_up",    2'd1, 1'b0, 2'd0);
    step("en0_down",  2'd2, 1'b0, 2'd0);

    // Count up with wrap
    step("up1", 2'd1, 1'b1, 2'd1);
    step("up2", 2'd1, 1'b1, 2'd2);
    step("up3", 2'd1, 1'b1, 2'd3);
    step("up_wrap", 2'd1, 1'b1, 2'd0);
    step("up5", 2'd1, 1'b1, 2'd1);

    // Count down with wrap
    step("dn1", 2'd2, 1'b1, 2'd0);
    step("dn_wrap", 2'd2, 1'b1, 2'd3);
    step("dn3", 2'd2, 1'b1, 2'd2);
    step("dn4", 2'd2, 1'b1, 2'd1);

    // En=0 holds a nonzero count even with clear/down requested
    step("en0_clear_hold", 2'd3, 1'b0, 2'd1);
    step("en0_down_hold",  2'd2, 1'b0, 2'd1);

    // Clear from 2, stays 0
    step("up_to2", 2'd1, 1'b1, 2'd2);
    step("clear", 2'd3, 1'b1, 2'd0);
    step("clear_s0_a", 2'd3, 1'b1, 2'd0);
    step("clear_s0_b", 2'd3, 1'b1, 2'd0);

    // Async reset mid-count at Cuenta=2
    step("cnt_a", 2'd1, 1'b1, 2'd1);
    step("cnt_b", 2'd1, 1'b1, 2'd2);
    #0.1 Rst = 1'b0;
    #0.2 check("midreset_immediate", Cuenta, 2'd0);
    #0.3 Rst = 1'b1;
    step("resume1", 2'd1, 1'b1, 2'd1);
    step("resume2", 2'd1, 1'b1, 2'd2);

    // Reset held across an edge while counting is requested
    Rst = 1'b0;
    step("reset_over_edge", 2'd1, 1'b1, 2'd0);
    Rst = 1'b1;
    step("resume_after_hold", 2'd1, 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
